// File: rtl/io_bus_arbiter.sv
// ============================================================================
// io_bus_arbiter : round-robin arbiter sharing a split-transaction IO bus
// Revision       : 1.0
// ============================================================================
`default_nettype none

module io_bus_arbiter #(
   parameter int NUM_MST  = 2,
   parameter int MAX_OUTS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_MST-1:0]      m_req,
   input  logic [NUM_MST-1:0]      m_wr,
   input  logic [4*NUM_MST-1:0]    m_wen,
   input  logic [32*NUM_MST-1:0]   m_addr,
   input  logic [32*NUM_MST-1:0]   m_wdata,
   output logic [NUM_MST-1:0]      m_req_ack,
   output logic [NUM_MST-1:0]      m_data_ack,
   output logic [31:0]             m_rdata,
   output logic                    io_req,
   output logic                    io_wr,
   output logic [3:0]              io_wen,
   output logic [31:0]             io_addr,
   output logic [31:0]             io_wdata,
   input  logic                    io_req_ack,
   input  logic [31:0]             io_rdata,
   input  logic                    io_data_ack,
   output logic                    err
);

   localparam int IDW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
   localparam int PW  = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
   localparam int CW  = $clog2(MAX_OUTS + 1);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t           state;
   logic [IDW-1:0]   lock_id;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   scan_g;
   logic [IDW-1:0]   g;
   logic [IDW-1:0]   head;
   logic [IDW:0]     idx_sum;
   logic             found;

   logic [IDW-1:0]   fifo [MAX_OUTS];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic             accept;
   logic             pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(MAX_OUTS - 1)) ptr_inc = '0;
      else                        ptr_inc = p + PW'(1);
   endfunction

   // First requester at or after rr_ptr, wrapping modulo NUM_MST.
   always_comb begin
      found   = 1'b0;
      scan_g  = '0;
      idx_sum = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         idx_sum = {1'b0, rr_ptr} + (IDW+1)'(i);
         if (idx_sum >= (IDW+1)'(NUM_MST)) idx_sum = idx_sum - (IDW+1)'(NUM_MST);
         if (!found && m_req[idx_sum[IDW-1:0]]) begin
            found  = 1'b1;
            scan_g = idx_sum[IDW-1:0];
         end
      end
   end

   assign g      = (state == ST_LOCKED) ? lock_id : scan_g;
   assign full   = (count == CW'(MAX_OUTS));
   assign empty  = (count == '0);
   assign head   = fifo[rd_ptr];
   assign io_req = m_req[g] & ~full & ~rst;
   assign accept = io_req & io_req_ack;
   assign pop    = io_data_ack & ~empty & ~rst;
   assign m_rdata = io_rdata;

   always_comb begin
      io_wr      = 1'b0;
      io_wen     = '0;
      io_addr    = '0;
      io_wdata   = '0;
      m_req_ack  = '0;
      m_data_ack = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         if (io_req && (g == IDW'(i))) begin
            io_wr        = m_wr[i];
            io_wen       = m_wen[4*i +: 4];
            io_addr      = m_addr[32*i +: 32];
            io_wdata     = m_wdata[32*i +: 32];
            m_req_ack[i] = io_req_ack;
         end
         if (pop && (head == IDW'(i))) m_data_ack[i] = 1'b1;
      end
   end

   // ID storage carries no reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (accept) fifo[wr_ptr] <= g;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         lock_id <= '0;
         rr_ptr  <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         err     <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= ptr_inc(wr_ptr);
            rr_ptr <= (g == IDW'(NUM_MST - 1)) ? '0 : g + IDW'(1);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({accept, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (io_data_ack && empty) err <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (io_req && !io_req_ack) begin
                  state   <= ST_LOCKED;
                  lock_id <= g;
               end
            end
            ST_LOCKED: begin
               // A master abandoning its pending request is a protocol violation.
               if (!m_req[lock_id]) begin
                  err   <= 1'b1;
                  state <= ST_IDLE;
               end else if (accept) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
// ============================================================================
// tb_io_bus_arbiter : directed self-checking bench for io_bus_arbiter
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_io_bus_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  m_req, m_wr;
   logic [7:0]  m_wen;
   logic [63:0] m_addr, m_wdata;
   logic [1:0]  m_req_ack, m_data_ack;
   logic [31:0] m_rdata;
   logic        io_req, io_wr;
   logic [3:0]  io_wen;
   logic [31:0] io_addr, io_wdata;
   logic        io_req_ack;
   logic [31:0] io_rdata;
   logic        io_data_ack;
   logic        err;

   int total = 0;
   int bad   = 0;

   io_bus_arbiter #(.NUM_MST(2), .MAX_OUTS(4)) dut (
      .clk(clk), .rst(rst),
      .m_req(m_req), .m_wr(m_wr), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_req_ack(m_req_ack), .m_data_ack(m_data_ack), .m_rdata(m_rdata),
      .io_req(io_req), .io_wr(io_wr), .io_wen(io_wen), .io_addr(io_addr), .io_wdata(io_wdata),
      .io_req_ack(io_req_ack), .io_rdata(io_rdata), .io_data_ack(io_data_ack),
      .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change 1 time unit after a rising edge; checks land on the falling edge.
   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic idle_inputs();
      m_req = '0; m_wr = '0; m_wen = '0; m_addr = '0; m_wdata = '0;
      io_req_ack = 1'b0; io_rdata = '0; io_data_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      m_req = 2'b11; io_req_ack = 1'b1; io_data_ack = 1'b1;
      next_cyc();
      next_cyc();
      settle();
      total++; if (io_req !== 1'b0) begin bad++; $display("FAIL rst_io_req: got %b want 0", io_req); end
      total++; if (m_req_ack !== 2'b00) begin bad++; $display("FAIL rst_req_ack: got %b want 00", m_req_ack); end
      total++; if (m_data_ack !== 2'b00) begin bad++; $display("FAIL rst_data_ack: got %b want 00", m_data_ack); end
      next_cyc();
      rst = 1'b0;
      idle_inputs();
      settle();
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
      total++; if ({io_req, io_wr, io_wen, io_addr, io_wdata} !== 70'd0) begin bad++; $display("FAIL rst_idle_bus: got req=%b addr=%h want all 0", io_req, io_addr); end
      next_cyc();
   endtask

   task automatic test_single_read();
      m_req = 2'b01; m_wr = 2'b00; m_addr = {32'h0, 32'hF000_0010}; io_req_ack = 1'b1;
      settle();
      total++; if (io_req !== 1'b1) begin bad++; $display("FAIL rd_io_req: got %b want 1", io_req); end
      total++; if (io_addr !== 32'hF000_0010) begin bad++; $display("FAIL rd_addr: got %h want f0000010", io_addr); end
      total++; if (io_wr !== 1'b0) begin bad++; $display("FAIL rd_wr: got %b want 0", io_wr); end
      total++; if (m_req_ack !== 2'b01) begin bad++; $display("FAIL rd_req_ack: got %b want 01", m_req_ack); end
      next_cyc();
      m_req = 2'b00; io_req_ack = 1'b0; io_data_ack = 1'b1; io_rdata = 32'h1122_3344;
      settle();
      total++; if (m_data_ack !== 2'b01) begin bad++; $display("FAIL rd_data_ack: got %b want 01", m_data_ack); end
      total++; if (m_rdata !== 32'h1122_3344) begin bad++; $display("FAIL rd_rdata: got %h want 11223344", m_rdata); end
      next_cyc();
      // rr_ptr is now 1: with both requesting, master1 must win.
      io_data_ack = 1'b0;
      m_req = 2'b11; m_addr = {32'hF000_0B00, 32'hF000_0A00};
      settle();
      total++; if (io_addr !== 32'hF000_0B00) begin bad++; $display("FAIL rd_rr_ptr: got %h want f0000b00", io_addr); end
      next_cyc();
      m_req = 2'b10; io_req_ack = 1'b1;
      settle();
      total++; if (m_req_ack !== 2'b10) begin bad++; $display("FAIL rd_rr_ack: got %b want 10", m_req_ack); end
      next_cyc();
      idle_inputs();
      io_data_ack = 1'b1;
      settle();
      total++; if (m_data_ack !== 2'b10) begin bad++; $display("FAIL rd_rr_data_ack: got %b want 10", m_data_ack); end
      next_cyc();
      idle_inputs();
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_ack;
      logic [31:0] exp_addr;
      m_req = 2'b11; m_addr = {32'h0000_0200, 32'h0000_0100}; io_req_ack = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_ack  = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_addr = (k % 2 == 0) ? 32'h100 : 32'h200;
         settle();
         total++; if (m_req_ack !== exp_ack) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", k, m_req_ack, exp_ack); end
         total++; if (io_addr !== exp_addr) begin bad++; $display("FAIL rr_addr%0d: got %h want %h", k, io_addr, exp_addr); end
         next_cyc();
      end
      idle_inputs();
      io_data_ack = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
         settle();
         total++; if (m_data_ack !== exp_ack) begin bad++; $display("FAIL rr_resp%0d: got %b want %b", k, m_data_ack, exp_ack); end
         next_cyc();
      end
      idle_inputs();
   endtask

   task automatic test_lock();
      // Move rr_ptr to 1 so an unlocked scan would prefer master1.
      m_req = 2'b01; m_addr = {32'h0, 32'h50}; io_req_ack = 1'b1;
      next_cyc();
      idle_inputs();
      io_data_ack = 1'b1;
      settle();
      total++; if (m_data_ack !== 2'b01) begin bad++; $display("FAIL lk_pre_resp: got %b want 01", m_data_ack); end
      next_cyc();
      idle_inputs();
      m_req = 2'b01; m_wr = 2'b01; m_addr = {32'h0000_00B0, 32'h0000_00A0};
      settle();
      total++; if (m_req_ack !== 2'b00) begin bad++; $display("FAIL lk_noack: got %b want 00", m_req_ack); end
      next_cyc();
      m_req = 2'b11;
      for (int k = 1; k < 3; k++) begin
         settle();
         total++; if ({io_wr, io_addr} !== {1'b1, 32'hA0}) begin bad++; $display("FAIL lk_hold%0d: got wr=%b addr=%h want wr=1 addr=a0", k, io_wr, io_addr); end
         next_cyc();
      end
      io_req_ack = 1'b1;
      settle();
      total++; if (m_req_ack !== 2'b01) begin bad++; $display("FAIL lk_accept0: got %b want 01", m_req_ack); end
      next_cyc();
      m_req = 2'b10;
      settle();
      total++; if ({m_req_ack, io_addr} !== {2'b10, 32'hB0}) begin bad++; $display("FAIL lk_accept1: got ack=%b addr=%h want ack=10 addr=b0", m_req_ack, io_addr); end
      next_cyc();
      idle_inputs();
      io_data_ack = 1'b1;
      settle();
      total++; if (m_data_ack !== 2'b01) begin bad++; $display("FAIL lk_resp0: got %b want 01", m_data_ack); end
      next_cyc();
      settle();
      total++; if (m_data_ack !== 2'b10) begin bad++; $display("FAIL lk_resp1: got %b want 10", m_data_ack); end
      next_cyc();
      idle_inputs();
   endtask

   task automatic test_full();
      m_req = 2'b01; m_addr = {32'h0, 32'h0000_0C00}; io_req_ack = 1'b1;
      for (int k = 0; k < 4; k++) begin
         settle();
         total++; if (m_req_ack !== 2'b01) begin bad++; $display("FAIL full_accept%0d: got %b want 01", k, m_req_ack); end
         next_cyc();
      end
      settle();
      total++; if ({io_req, m_req_ack} !== 3'b000) begin bad++; $display("FAIL full_block: got req=%b ack=%b want 0/00", io_req, m_req_ack); end
      next_cyc();
      io_data_ack = 1'b1;
      settle();
      total++; if (m_data_ack !== 2'b01) begin bad++; $display("FAIL full_pop: got %b want 01", m_data_ack); end
      total++; if (io_req !== 1'b0) begin bad++; $display("FAIL full_nobypass: got %b want 0", io_req); end
      next_cyc();
      io_data_ack = 1'b0;
      settle();
      total++; if ({io_req, m_req_ack} !== 3'b101) begin bad++; $display("FAIL full_reissue: got req=%b ack=%b want 1/01", io_req, m_req_ack); end
      next_cyc();
      idle_inputs();
      io_data_ack = 1'b1;
      for (int k = 0; k < 4; k++) begin
         settle();
         total++; if (m_data_ack !== 2'b01) begin bad++; $display("FAIL full_drain%0d: got %b want 01", k, m_data_ack); end
         next_cyc();
      end
      idle_inputs();
   endtask

   task automatic test_write_routing();
      m_req = 2'b10; m_wr = 2'b10; m_wen = {4'b0011, 4'b1111};
      m_addr = {32'hF000_0002, 32'h1234_5678}; m_wdata = {32'hDEAD_BEEF, 32'h5555_5555};
      io_req_ack = 1'b1;
      settle();
      total++; if (io_wen !== 4'b0011) begin bad++; $display("FAIL wr_wen: got %b want 0011", io_wen); end
      total++; if (io_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_wdata: got %h want deadbeef", io_wdata); end
      total++; if ({io_wr, io_addr} !== {1'b1, 32'hF000_0002}) begin bad++; $display("FAIL wr_addr: got wr=%b addr=%h want wr=1 addr=f0000002", io_wr, io_addr); end
      total++; if (m_req_ack !== 2'b10) begin bad++; $display("FAIL wr_req_ack: got %b want 10", m_req_ack); end
      next_cyc();
      m_req = 2'b00; io_req_ack = 1'b0; io_data_ack = 1'b1; io_rdata = 32'hCAFE_F00D;
      settle();
      total++; if (m_data_ack !== 2'b10) begin bad++; $display("FAIL wr_data_ack: got %b want 10", m_data_ack); end
      total++; if (m_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL wr_rdata: got %h want cafef00d", m_rdata); end
      total++; if ({io_wr, io_wen, io_addr, io_wdata} !== 69'd0) begin bad++; $display("FAIL wr_idle_zero: got wen=%b wdata=%h want 0", io_wen, io_wdata); end
      next_cyc();
      idle_inputs();
   endtask

   task automatic test_errors_reset();
      settle();
      total++; if (err !== 1'b0) begin bad++; $display("FAIL er_clean: got %b want 0", err); end
      next_cyc();
      io_data_ack = 1'b1;
      settle();
      total++; if (m_data_ack !== 2'b00) begin bad++; $display("FAIL er_empty_ack: got %b want 00", m_data_ack); end
      next_cyc();
      io_data_ack = 1'b0;
      settle();
      total++; if (err !== 1'b1) begin bad++; $display("FAIL er_set: got %b want 1", err); end
      next_cyc();
      m_req = 2'b01; m_addr = {32'h0, 32'h0000_0E00}; io_req_ack = 1'b1;
      settle();
      total++; if (err !== 1'b1) begin bad++; $display("FAIL er_sticky: got %b want 1", err); end
      next_cyc();
      next_cyc();
      rst = 1'b1;
      settle();
      total++; if ({io_req, m_req_ack} !== 3'b000) begin bad++; $display("FAIL er_rst_req: got req=%b ack=%b want 0/00", io_req, m_req_ack); end
      next_cyc();
      rst = 1'b0;
      idle_inputs();
      settle();
      total++; if (err !== 1'b0) begin bad++; $display("FAIL er_rst_clear: got %b want 0", err); end
      next_cyc();
      io_data_ack = 1'b1;
      settle();
      total++; if (m_data_ack !== 2'b00) begin bad++; $display("FAIL er_flushed_ack: got %b want 00", m_data_ack); end
      next_cyc();
      io_data_ack = 1'b0;
      settle();
      total++; if (err !== 1'b1) begin bad++; $display("FAIL er_flushed_err: got %b want 1", err); end
      next_cyc();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      #1;
      test_reset();
      test_single_read();
      test_round_robin();
      test_lock();
      test_full();
      test_write_routing();
      test_errors_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
